md_unit: RTL and testbench

- Multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage beside the ALU. Consumes the GRF read values (rs/rt) and the control-decoded md_op.
- Produces HI/LO for mfhi/mflo writeback, plus a busy flag the core uses to stall subsequent md instructions.
- Models fixed multi-cycle latency: mult/multu 5 cycles, div/divu 10 cycles.

---
 rtl/md_unit_pkg.sv | 27 ++
 rtl/md_unit_if.sv | 30 +++
 rtl/md_unit_div32.sv | 59 +++++
 rtl/md_unit.sv | 134 +++++++++++++
 tb/tb_md_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_pkg
//  Description : Shared md_op encodings and default latencies for the
//                multiply/divide unit and the control decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_unit_pkg;

    // Operation select carried from the control decoder to the md unit
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    // Default busy latencies (must fit the 4-bit countdown: 1..15)
    localparam int unsigned c_MULT_CYCLES_DEF = 5;
    localparam int unsigned c_DIV_CYCLES_DEF  = 10;

endpackage : md_unit_pkg
`default_nettype wire

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_if
//  Description : Execute-stage request / HI-LO result bundle between the
//                core datapath (master) and the md unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_if;
    import md_unit_pkg::*;

    logic        start;
    md_op_e      md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_val, rt_val,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val,
        output busy, hi, lo
    );

endinterface : md_unit_if
`default_nettype wire

// File: rtl/md_unit_div32.sv
`default_nettype none
// ============================================================================
//  Module      : md_div32
//  Description : Combinational 32-bit signed/unsigned divide. Quotient
//                truncates toward zero, remainder takes the dividend's sign.
//                Zero divisor and the 0x80000000 / -1 overflow are handled
//                on their own paths so the general path never sees them.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_div32 (
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    input  wire logic        i_signed,
    output logic      [31:0] o_quot,
    output logic      [31:0] o_rem,
    output logic             o_div_zero
);

    logic        w_zero;
    logic        w_ovf;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_safe_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_zero   = (i_b == 32'd0);
    assign w_ovf    = i_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    assign w_neg_a  = i_signed & i_a[31];
    assign w_neg_b  = i_signed & i_b[31];
    assign w_mag_a  = w_neg_a ? (32'd0 - i_a) : i_a;
    assign w_mag_b  = w_neg_b ? (32'd0 - i_b) : i_b;
    // Never present a zero divisor to the divider core
    assign w_safe_b = w_zero ? 32'd1 : w_mag_b;
    assign w_uq     = w_mag_a / w_safe_b;
    assign w_ur     = w_mag_a % w_safe_b;

    assign o_div_zero = w_zero;

    // Select special-case results, otherwise re-apply signs to magnitudes
    always_comb begin
        o_quot = 32'd0;
        o_rem  = 32'd0;
        if (w_zero) begin
            o_quot = 32'd0;
            o_rem  = 32'd0;
        end else if (w_ovf) begin
            o_quot = 32'h8000_0000;
            o_rem  = 32'd0;
        end else begin
            o_quot = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
            o_rem  = w_neg_a ? (32'd0 - w_ur) : w_ur;
        end
    end

endmodule : md_div32
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Multiply/divide unit with architectural HI/LO. Results are
//                computed at issue and held in a pending register; a 4-bit
//                countdown models the fixed latency and commits the pending
//                value to HI/LO on its final tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = c_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = c_DIV_CYCLES_DEF
) (
    input  wire logic clk,
    input  wire logic reset,
    md_unit_if.slave  bus
);

    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_phi;
    logic [31:0] r_plo;
    logic        r_pwr;

    logic        w_idle;
    logic        w_issue;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_zero;
    logic        w_div_signed;

    logic        w_ld_pend;
    logic [63:0] w_pend;
    logic        w_pend_wr;
    logic [3:0]  w_cnt_init;
    logic        w_wr_hi;
    logic        w_wr_lo;

    assign w_idle  = (r_cnt == 4'd0);
    // Requests arriving while busy are dropped, mthi/mtlo included
    assign w_issue = bus.start & w_idle;

    // Sign-/zero-extend to 64 bits so the low 64 product bits are exact
    assign w_prod_s = {{32{bus.rs_val[31]}}, bus.rs_val} * {{32{bus.rt_val[31]}}, bus.rt_val};
    assign w_prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

    assign w_div_signed = (bus.md_op == MD_DIV);

    md_div32 u_div32 (
        .i_a        (bus.rs_val),
        .i_b        (bus.rt_val),
        .i_signed   (w_div_signed),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_div_zero (w_div_zero)
    );

    // Decode an accepted request into pending-load and direct HI/LO writes
    always_comb begin
        w_ld_pend  = 1'b0;
        w_pend     = 64'd0;
        w_pend_wr  = 1'b0;
        w_cnt_init = 4'd0;
        w_wr_hi    = 1'b0;
        w_wr_lo    = 1'b0;
        if (w_issue) begin
            case (bus.md_op)
                MD_MULT: begin
                    w_ld_pend  = 1'b1;
                    w_pend     = w_prod_s;
                    w_pend_wr  = 1'b1;
                    w_cnt_init = 4'(MULT_CYCLES);
                end
                MD_MULTU: begin
                    w_ld_pend  = 1'b1;
                    w_pend     = w_prod_u;
                    w_pend_wr  = 1'b1;
                    w_cnt_init = 4'(MULT_CYCLES);
                end
                MD_DIV, MD_DIVU: begin
                    // Divide by zero still occupies the unit but never commits
                    w_ld_pend  = 1'b1;
                    w_pend     = {w_rem, w_quot};
                    w_pend_wr  = ~w_div_zero;
                    w_cnt_init = 4'(DIV_CYCLES);
                end
                MD_MTHI: w_wr_hi = 1'b1;
                MD_MTLO: w_wr_lo = 1'b1;
                default: ;
            endcase
        end
    end

    // Countdown, commit on the 1->0 tick, and accept new work when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_phi <= 32'd0;
            r_plo <= 32'd0;
            r_pwr <= 1'b0;
        end else if (!w_idle) begin
            r_cnt <= r_cnt - 4'd1;
            if ((r_cnt == 4'd1) && r_pwr) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end
        end else begin
            if (w_ld_pend) begin
                r_cnt          <= w_cnt_init;
                {r_phi, r_plo} <= w_pend;
                r_pwr          <= w_pend_wr;
            end
            if (w_wr_hi) begin
                r_hi <= bus.rs_val;
            end
            if (w_wr_lo) begin
                r_lo <= bus.rs_val;
            end
        end
    end

    assign bus.busy = ~w_idle;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule : md_unit
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Scoreboard bench for md_unit. Stimulus pushes hand-computed
//                HI/LO results; a monitor checks them when busy falls and
//                checks HI/LO hold steady while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;
    import md_unit_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] phi;
        logic [31:0] plo;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    md_unit_if bus ();

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Protocol watch: the core should never raise start while busy
    always @(posedge clk) begin
        if (reset && bus.start && bus.busy)
            $display("note: start raised while busy at %0t (protocol violation, ignored)", $time);
    end

    // Monitor: hold check during busy, result check when busy falls
    int bcnt  = 0;
    bit prevb = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            bcnt  = 0;
            prevb = 1'b0;
        end else begin
            if (bus.busy) begin
                bcnt++;
                if (q.size() == 0) begin
                    chk("unexpected_busy", 64'(bus.busy), 64'd0);
                end else begin
                    chk({q[0].name, "_hold"}, {bus.hi, bus.lo}, {q[0].phi, q[0].plo});
                end
            end else if (prevb) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'(prevb), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, "_cycles"}, 64'(bcnt), 64'(e.cyc));
                    chk({e.name, "_hilo"}, {bus.hi, bus.lo}, {e.hi, e.lo});
                end
                bcnt = 0;
            end
            prevb = bus.busy;
        end
    end

    // Issue a multi-cycle op now; it is sampled at the next rising edge
    task automatic issue(input string nm, input md_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input int cyc);
        exp_t e;
        e.name = nm; e.hi = ehi; e.lo = elo; e.phi = m_hi; e.plo = m_lo; e.cyc = cyc;
        q.push_back(e);
        m_hi = ehi;
        m_lo = elo;
        bus.start  = 1'b1;
        bus.md_op  = op;
        bus.rs_val = a;
        bus.rt_val = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.md_op = MD_NONE;
    endtask

    // mthi/mtlo: visible right after the sampling edge, no busy
    task automatic mt(input string nm, input md_op_e op, input logic [31:0] v);
        bus.start  = 1'b1;
        bus.md_op  = op;
        bus.rs_val = v;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.md_op = MD_NONE;
        if (op == MD_MTHI) m_hi = v;
        else               m_lo = v;
        chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
        chk({nm, "_hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
    endtask

    // Returns just after the negedge at which the scoreboard drained
    task automatic wait_idle(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got pending=%0d required 0", nm, q.size());
        q.delete();
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.md_op  = MD_NONE;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        issue("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
        wait_idle("mult_neg");
        issue("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
        wait_idle("multu_max");
        issue("mult_pos", MD_MULT, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 5);
        wait_idle("mult_pos");
        issue("div_neg_dvd", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        wait_idle("div_neg_dvd");
        issue("div_neg_dvs", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
        wait_idle("div_neg_dvs");
        issue("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        wait_idle("divu");

        mt("mthi", MD_MTHI, 32'h11);
        mt("mtlo", MD_MTLO, 32'h22);
        issue("divu_zero", MD_DIVU, 32'd7, 32'd0, 32'h11, 32'h22, 10);
        wait_idle("divu_zero");
        issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
        wait_idle("div_ovf");

        // mtlo during busy must be dropped; mtlo right as busy falls is taken
        issue("mult_blocked", MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        bus.start  = 1'b1;
        bus.md_op  = MD_MTLO;
        bus.rs_val = 32'hAB;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.md_op = MD_NONE;
        wait_idle("mult_blocked");
        mt("mtlo_b2b", MD_MTLO, 32'hAB);

        // Asynchronous reset in the middle of a divide
        issue("div_reset", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        chk("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_late_commit", {31'd0, bus.busy, bus.hi, bus.lo}, 64'd0);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_md_unit
`default_nettype wire
